// File: rtl/counter_run_scheduler.sv
// Round-robin front end for one shared loadable up-counter: grants a requester a
// timed run (load start value, count to end value) and pulses done on completion.
module counter_run_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 5
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_start,
  input  logic [NUM_REQ*WIDTH-1:0] req_end,
  input  logic                     pause,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     cnt_load,
  output logic                     cnt_enable,
  output logic [WIDTH-1:0]         cnt_data,
  input  logic [WIDTH-1:0]         cnt_count
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [IW-1:0]    r_win, r_rr, w_pick;
  logic [WIDTH-1:0] r_start, r_end;
  logic             w_found, w_abort, w_at_end;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    idx     = 0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_pick  = IW'(idx);
      end
    end
  end

  assign w_abort  = !req[r_win];
  assign w_at_end = (cnt_count == r_end);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_next = S_LOAD;
      S_LOAD: w_next = w_abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (w_abort)       w_next = S_IDLE;
        else if (w_at_end) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state <= S_IDLE;
      r_rr    <= IW'(NUM_REQ - 1);
      r_win   <= '0;
      r_start <= '0;
      r_end   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) begin
        r_win   <= w_pick;
        r_start <= req_start[int'(w_pick)*WIDTH +: WIDTH];
        r_end   <= req_end[int'(w_pick)*WIDTH +: WIDTH];
      end
      // Aborted runs still rotate priority so a flapping requester cannot hog the counter.
      if (r_state == S_DONE || ((r_state == S_LOAD || r_state == S_RUN) && w_abort))
        r_rr <= r_win;
    end
  end

  always_comb begin
    gnt = '0;
    done = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i]  = (r_state != S_IDLE) && (r_win == IW'(i));
      done[i] = (r_state == S_DONE) && (r_win == IW'(i));
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign cnt_load   = (r_state == S_LOAD);
  assign cnt_data   = (r_state == S_LOAD) ? r_start : '0;
  // Gating on abort keeps the counter frozen on the cycle the requester leaves.
  assign cnt_enable = (r_state == S_RUN) && !pause && !w_at_end && !w_abort;

endmodule

// File: tb/tb_counter_run_scheduler.sv
// Directed bench for counter_run_scheduler with a behavioural shared counter.
module tb_counter_run_scheduler;
  localparam int N = 2;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst_;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_start, req_end;
  logic           pause;
  logic [N-1:0]   gnt, done;
  logic           busy, cnt_load, cnt_enable;
  logic [W-1:0]   cnt_data, cnt_q;

  int n_chk = 0;
  int n_fail = 0;
  int inv_err = 0;

  counter_run_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_(rst_), .req(req), .req_start(req_start), .req_end(req_end),
    .pause(pause), .gnt(gnt), .done(done), .busy(busy), .cnt_load(cnt_load),
    .cnt_enable(cnt_enable), .cnt_data(cnt_data), .cnt_count(cnt_q)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (!rst_)           cnt_q <= '0;
    else if (cnt_load)   cnt_q <= cnt_data;
    else if (cnt_enable) cnt_q <= cnt_q + 1'b1;
  end

  always @(negedge clk) begin
    if (rst_ === 1'b1) begin
      if ((cnt_load && cnt_enable) || (!cnt_load && cnt_data != 0) ||
          ((done & ~gnt) != 0) || !$onehot0(gnt) || !$onehot0(done))
        inv_err++;
    end
  end

  task automatic do_reset();
    rst_ = 1'b0; req = '0; pause = 1'b0; req_start = '0; req_end = '0;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;
  endtask

  // Raise mask in an IDLE cycle (cycle 0) and record what happens in cycles 1..80.
  task automatic run_obs(input logic [N-1:0] mask, input int pa, input int pl,
                         input bit scram, input logic [W-1:0] endv,
                         output int load_cyc, output int load_data, output int en_cnt,
                         output int done_cyc, output logic [N-1:0] done_vec,
                         output int bad_en);
    load_cyc = -1; load_data = -1; en_cnt = 0; done_cyc = -1; done_vec = '0; bad_en = 0;
    @(negedge clk);
    req = mask;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      pause = (c >= pa && c < pa + pl);
      if (scram && c == 2) begin
        req_start = ~req_start;
        req_end   = ~req_end;
      end
      #1;
      if (cnt_load && load_cyc < 0) begin
        load_cyc  = c;
        load_data = int'(cnt_data);
      end
      if (cnt_enable) en_cnt++;
      if (cnt_enable && cnt_q == endv) bad_en++;
      if (done != 0) begin
        done_cyc = c;
        done_vec = done;
        break;
      end
    end
    req = '0;
    pause = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; req = 2'b01; pause = 1'b0; req_start = '0; req_end = 10'd31 << W;
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if ({gnt, done} !== '0) begin
      n_fail++; $display("FAIL reset_gnt_done: got gnt=%b done=%b, want 0", gnt, done);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b, want 0", busy);
    end
    n_chk++;
    if ({cnt_load, cnt_enable, cnt_data} !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got load=%b en=%b data=%0d, want 0", cnt_load, cnt_enable, cnt_data);
    end
    req = '0;
  endtask

  task automatic test_single();
    int lc, ld, en, dc, be;
    logic [N-1:0] dv;
    do_reset();
    req_start[0 +: W] = 5'd3; req_end[0 +: W] = 5'd7;
    run_obs(2'b01, 0, 0, 1'b1, 5'd7, lc, ld, en, dc, dv, be);
    n_chk++;
    if (lc !== 1 || ld !== 3) begin
      n_fail++; $display("FAIL single_load: got cyc=%0d data=%0d, want cyc=1 data=3", lc, ld);
    end
    n_chk++;
    if (en !== 4) begin
      n_fail++; $display("FAIL single_enables: got %0d, want 4", en);
    end
    n_chk++;
    if (dc !== 7 || dv !== 2'b01) begin
      n_fail++; $display("FAIL single_done: got cyc=%0d vec=%b, want cyc=7 vec=01", dc, dv);
    end
    n_chk++;
    if (cnt_q !== 5'd7) begin
      n_fail++; $display("FAIL single_count: got %0d, want 7", cnt_q);
    end
  endtask

  task automatic test_wrap();
    int lc, ld, en, dc, be;
    logic [N-1:0] dv;
    do_reset();
    req_start[0 +: W] = 5'd30; req_end[0 +: W] = 5'd2;
    run_obs(2'b01, 0, 0, 1'b0, 5'd2, lc, ld, en, dc, dv, be);
    n_chk++;
    if (en !== 4 || dc !== 7 || dv !== 2'b01) begin
      n_fail++; $display("FAIL wrap_run: got en=%0d done_cyc=%0d vec=%b, want 4 7 01", en, dc, dv);
    end
    n_chk++;
    if (be !== 0 || cnt_q !== 5'd2) begin
      n_fail++; $display("FAIL wrap_end: got en_at_end=%0d count=%0d, want 0 2", be, cnt_q);
    end
  endtask

  task automatic test_zero();
    int lc, ld, en, dc, be;
    logic [N-1:0] dv;
    do_reset();
    req_start[0 +: W] = 5'd9; req_end[0 +: W] = 5'd9;
    run_obs(2'b01, 0, 0, 1'b0, 5'd9, lc, ld, en, dc, dv, be);
    n_chk++;
    if (lc !== 1 || ld !== 9 || en !== 0 || dc !== 3) begin
      n_fail++; $display("FAIL zero_len: got load=%0d data=%0d en=%0d done=%0d, want 1 9 0 3", lc, ld, en, dc);
    end
  endtask

  task automatic test_pause();
    int lc, ld, en, dc, be;
    logic [N-1:0] dv;
    do_reset();
    req_start[0 +: W] = 5'd3; req_end[0 +: W] = 5'd7;
    run_obs(2'b01, 3, 3, 1'b0, 5'd7, lc, ld, en, dc, dv, be);
    n_chk++;
    if (dc !== 10 || en !== 4 || cnt_q !== 5'd7) begin
      n_fail++; $display("FAIL pause_delay: got done=%0d en=%0d count=%0d, want 10 4 7", dc, en, cnt_q);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [4];
    int cyc [4];
    int nd, gap_err;
    logic [N-1:0] exp_seq [4];
    int exp_cyc [4];
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_cyc = '{5, 11, 17, 23};
    nd = 0; gap_err = 0;
    do_reset();
    req_start = {5'd5, 5'd0}; req_end = {5'd7, 5'd2};
    @(negedge clk);
    req = 2'b11;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #2;
      if (nd > 0 && cyc[nd-1] == c - 1 && busy !== 1'b0) gap_err++;
      if (done != 0 && nd < 4) begin
        seq[nd] = done; cyc[nd] = c; nd++;
      end
    end
    req = '0;
    repeat (2) @(posedge clk);
    n_chk++;
    if (nd !== 4) begin
      n_fail++; $display("FAIL rr_count: got %0d done pulses, want 4", nd);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (seq[i] !== exp_seq[i] || cyc[i] !== exp_cyc[i]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: got vec=%b cyc=%0d, want vec=%b cyc=%0d", i, seq[i], cyc[i], exp_seq[i], exp_cyc[i]);
        end
      end
    end
    n_chk++;
    if (gap_err !== 0) begin
      n_fail++; $display("FAIL rr_idle_gap: got %0d busy cycles after done, want 0", gap_err);
    end
  endtask

  task automatic test_abort();
    int saw_done;
    saw_done = 0;
    do_reset();
    req_start = {5'd0, 5'd0}; req_end = {5'd10, 5'd10};
    @(negedge clk);
    req = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) req = 2'b00;
      #1;
      if (done != 0) saw_done++;
      if (c == 4) begin
        n_chk++;
        if (busy !== 1'b0 || gnt !== 2'b00 || cnt_q !== 5'd1) begin
          n_fail++; $display("FAIL abort_idle: got busy=%b gnt=%b count=%0d, want 0 00 1", busy, gnt, cnt_q);
        end
        req = 2'b11;
      end
      if (c == 5) begin
        n_chk++;
        if (gnt !== 2'b01) begin
          n_fail++; $display("FAIL abort_next_gnt: got %b, want 01", gnt);
        end
      end
    end
    n_chk++;
    if (saw_done !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d done pulses, want 0", saw_done);
    end
    req = '0;
  endtask

  task automatic test_reset_midrun();
    int lc, ld, en, dc, be;
    logic [N-1:0] dv;
    do_reset();
    req_start[0 +: W] = 5'd0; req_end[0 +: W] = 5'd20;
    @(negedge clk);
    req = 2'b01;
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b0;
    @(posedge clk);
    #2;
    n_chk++;
    if ({gnt, done, busy, cnt_load, cnt_enable, cnt_data} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got gnt=%b done=%b busy=%b load=%b en=%b data=%0d, want all 0",
               gnt, done, busy, cnt_load, cnt_enable, cnt_data);
    end
    rst_ = 1'b1; req = '0;
    req_start = '0; req_end = {5'd1, 5'd1};
    run_obs(2'b11, 0, 0, 1'b0, 5'd1, lc, ld, en, dc, dv, be);
    n_chk++;
    if (dc !== 4 || dv !== 2'b01) begin
      n_fail++; $display("FAIL midrun_restart: got done=%0d vec=%b, want 4 01", dc, dv);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_zero();
    test_pause();
    test_round_robin();
    test_abort();
    test_reset_midrun();
    n_chk++;
    if (inv_err !== 0) begin
      n_fail++; $display("FAIL invariants: got %0d violating cycles, want 0", inv_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
